// File: rtl/regfile.sv
// Register file with 2**ADDR_W x DATA_W entries, two combinational read ports and one write port.
// Entry 0 always reads as zero. Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREGS];
    logic              wr_ok;

    assign wr_ok = we && (wa != '0);

    // Reset wins over a simultaneous write; x0 is only ever written with zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    assign stored1 = (ra1 == '0) ? '0 : mem[ra1];
    assign stored2 = (ra2 == '0) ? '0 : mem[ra2];

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Forwarding is blocked during reset, since that write will be lost.
    assign fwd1 = wr_ok && !rst && (ra1 == wa);
    assign fwd2 = wr_ok && !rst && (ra2 == wa);

    assign rd1 = fwd1 ? wd : stored1;
    assign rd2 = fwd2 ? wd : stored2;
`else
    assign rd1 = stored1;
    assign rd2 = stored2;
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, reset sweeps and random traffic vs. an array model.
// Expectations follow the build: REGFILE_BYPASS_EN selects forwarding behaviour.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int total;
    int bad;

    logic [31:0] model [32];

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [15];

    regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .ra1(ra1),
        .ra2(ra2),
        .wa(wa),
        .wd(wd),
        .rd1(rd1),
        .rd2(rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference read: x0 is zero, a live write is forwarded only in the bypass build and never during reset.
    function automatic logic [31:0] expRead(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (BYP && we && !rst && wa != 5'd0 && wa == addr) return wd;
        return model[addr];
    endfunction

    task automatic applyStimulus(input logic r, input logic w, input logic [4:0] a,
                                 input logic [31:0] d, input logic [4:0] p1, input logic [4:0] p2);
        rst = r;
        we  = w;
        wa  = a;
        wd  = d;
        ra1 = p1;
        ra2 = p2;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] exp1, input logic [31:0] exp2);
        total++;
        if (rd1 !== exp1) begin
            bad++;
            $display("[TB] FAIL %s rd1: got %h expected %h (ra1=%0d)", name, rd1, exp1, ra1);
        end
        total++;
        if (rd2 !== exp2) begin
            bad++;
            $display("[TB] FAIL %s rd2: got %h expected %h (ra2=%0d)", name, rd2, exp2, ra2);
        end
    endtask

    // Advance one clock and apply the same architectural update to the model.
    task automatic clockEdge();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
        #1;
    endtask

    task automatic resetSweep(input string name);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        clockEdge();
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, a[4:0], 5'(31 - a));
            checkOutput(name, 32'd0, 32'd0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        //              rst   we    wa     wd             ra1    ra2    exp1                       exp2
        vecs[0]  = '{1'b0, 1'b1, 5'd2, 32'h00000005, 5'd2, 5'd0, BYP ? 32'h5 : 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd3, 32'h0000000A, 5'd2, 5'd3, 32'h5,                      BYP ? 32'hA : 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'h00000000, 5'd2, 5'd3, 32'h5,                      32'hA};
        vecs[3]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0,                      32'h0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h00000000, 5'd0, 5'd0, 32'h0,                      32'h0};
        vecs[5]  = '{1'b0, 1'b0, 5'd4, 32'h12345678, 5'd4, 5'd4, 32'h0,                      32'h0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h00000000, 5'd4, 5'd2, 32'h0,                      32'h5};
        vecs[7]  = '{1'b0, 1'b1, 5'd5, 32'h00000001, 5'd0, 5'd0, 32'h0,                      32'h0};
        vecs[8]  = '{1'b0, 1'b1, 5'd5, 32'h00000007, 5'd5, 5'd5, BYP ? 32'h7 : 32'h1,        BYP ? 32'h7 : 32'h1};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h00000000, 5'd5, 5'd3, 32'h7,                      32'hA};
        vecs[10] = '{1'b1, 1'b1, 5'd6, 32'h00000009, 5'd6, 5'd5, 32'h0,                      32'h7};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 32'h00000000, 5'd6, 5'd5, 32'h0,                      32'h0};
        vecs[12] = '{1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7, BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
        vecs[13] = '{1'b0, 1'b1, 5'd8, 32'h00000001, 5'd7, 5'd8, 32'hDEADBEEF,               BYP ? 32'h1 : 32'h0};
        vecs[14] = '{1'b0, 1'b0, 5'd0, 32'h00000000, 5'd8, 5'd7, 32'h1,                      32'hDEADBEEF};

        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        @(posedge clk);
        #1;

        // Dirty several registers so the reset sweep proves clearing, not power-up state.
        for (int i = 1; i < 32; i += 3) begin
            applyStimulus(1'b0, 1'b1, i[4:0], 32'hA5A50000 | 32'(i), 5'd0, 5'd0);
            clockEdge();
        end
        resetSweep("reset_sweep");

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp1, vecs[i].exp2);
            clockEdge();
        end

        // Random traffic; reads often target the write address to exercise the hazard path.
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        w;
            logic [4:0]  a;
            logic [4:0]  p1;
            logic [4:0]  p2;
            logic [31:0] d;
            r  = ($urandom_range(0, 39) == 0);
            w  = ($urandom_range(0, 3) != 0);
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            p1 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
            p2 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
            applyStimulus(r, w, a, d, p1, p2);
            checkOutput("random", expRead(ra1), expRead(ra2));
            clockEdge();
        end

        resetSweep("final_reset_sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
